// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Frame state encoding, data-bit selector and line levels for the UART TX/RX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // Keeps only the bits that belong to the selected frame width.
  function automatic logic [7:0] data_mask(data_bits_e bits);
    return 8'hFF >> (2'd3 - bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - ready/valid byte input channel of the UART transmitter
interface uart_tx_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous first-word-fall-through FIFO
// Shared by the UART TX and RX paths; DEPTH must be a power of two.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with runtime frame format
// Byte FIFO, baud divider and frame serialiser; frames run back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter int  BAUD_W     = 12,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_fifo_if.slave     in_if,
  input  logic [BAUD_W-1:0] baud_divisor,
  input  logic [1:0]        cfg_data_bits,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              cfg_two_stop,
  input  logic              tx_enable,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  fifo_count
);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_W-1:0] div_q, div_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  data_bits_e        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_out_q, tx_out_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              bit_end, start_ok, load, next_bit;
  logic [7:0]        masked;
  data_bits_e        cfg_bits;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_if.in_valid),
    .push_data_i (in_if.in_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;
  assign busy           = (state_q != IDLE);
  assign tx_out         = tx_out_q;
  assign bit_end        = (baud_cnt_q == div_q);
  assign start_ok       = tx_enable && !fifo_empty;
  assign cfg_bits       = data_bits_e'(cfg_data_bits);
  assign masked         = fifo_rdata & data_mask(cfg_bits);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    div_d      = div_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    load       = 1'b0;
    next_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        load       = start_ok;
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          next_bit = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          next_bit = 1'b1;
          if (bit_idx_q == {1'b1, nbits_q}) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          next_bit = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            next_bit   = 1'b1;
          end else begin
            frame_done = 1'b1;
            load       = start_ok;
            if (!start_ok) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The whole frame format is captured here so later cfg changes cannot corrupt it.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      shreg_d    = masked;
      nbits_d    = cfg_bits;
      par_en_d   = cfg_parity_en;
      par_bit_d  = (^masked) ^ cfg_parity_odd;
      two_stop_d = cfg_two_stop;
      bit_idx_d  = 3'd0;
      stop_idx_d = 1'b0;
      next_bit   = 1'b1;
    end

    if (next_bit) begin
      baud_cnt_d = '0;
      div_d      = baud_divisor;
    end

    case (state_d)
      START:   tx_out_d = ~IDLE_LEVEL;
      DATA:    tx_out_d = shreg_d[0];
      PARITY:  tx_out_d = par_bit_d;
      default: tx_out_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= BITS_8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_out_q   <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      tx_out_q   <= tx_out_d;
    end
  end

endmodule
